// File: rtl/vga_timing_gen_if.sv
// Timing generator <-> raster consumer bundle: run control in, pixel strobe/sync/coords out.
// Master is the generator; slave is the consumer that drives run.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10,
  parameter int FRM_W = 16
);
  logic             run;
  logic             pix_en;
  logic             hs;
  logic             vs;
  logic             active_nblank;
  logic [CNT_W-1:0] draw_x;
  logic [CNT_W-1:0] draw_y;
  logic             line_start;
  logic             frame_start;
  logic             running;
  logic [FRM_W-1:0] frame_count;

  modport master (
    input  run,
    output pix_en, hs, vs, active_nblank, draw_x, draw_y,
           line_start, frame_start, running, frame_count
  );

  modport slave (
    output run,
    input  pix_en, hs, vs, active_nblank, draw_x, draw_y,
           line_start, frame_start, running, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator with a divided pixel strobe and frame-boundary run/stop.
// Outputs decode combinationally from registered state (zero latency); no backpressure, run is a level.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10,
  parameter int FRM_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG   = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG   = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic [FRM_W-1:0] frm_q;

  logic running;
  logic pix_en;
  logic x_last;
  logic y_last;
  logic frame_end;
  logic in_hs;
  logic in_vs;

  assign running   = (state_q != ST_IDLE);
  assign pix_en    = running && (div_cnt == DIV_LAST);
  assign x_last    = (x_q == H_LAST);
  assign y_last    = (y_q == V_LAST);
  assign frame_end = pix_en && x_last && y_last;

  assign in_hs = (int'(x_q) >= HS_BEG) && (int'(x_q) < HS_END);
  assign in_vs = (int'(y_q) >= VS_BEG) && (int'(y_q) < VS_END);

  // Stop requests only take effect on the last pixel of a frame, so a frame is never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (vif.run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (frame_end)     state_d = vif.run ? ST_RUN : ST_IDLE;
        else if (!vif.run) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_end)     state_d = vif.run ? ST_RUN : ST_IDLE;
        else if (vif.run)  state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_cnt <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;

      if (!running || pix_en) div_cnt <= '0;
      else                    div_cnt <= div_cnt + DIV_W'(1);

      if (pix_en) begin
        if (x_last) begin
          x_q <= '0;
          if (y_last) begin
            y_q   <= '0;
            frm_q <= frm_q + FRM_W'(1);
          end else begin
            y_q <= y_q + CNT_W'(1);
          end
        end else begin
          x_q <= x_q + CNT_W'(1);
        end
      end
    end
  end

  assign vif.pix_en        = pix_en;
  assign vif.hs            = (running && in_hs) ? HS_POL : ~HS_POL;
  assign vif.vs            = (running && in_vs) ? VS_POL : ~VS_POL;
  assign vif.active_nblank = running && (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
  assign vif.draw_x        = x_q;
  assign vif.draw_y        = y_q;
  assign vif.line_start    = pix_en && (x_q == '0);
  assign vif.frame_start   = pix_en && (x_q == '0) && (y_q == '0);
  assign vif.running       = running;
  assign vif.frame_count   = frm_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing on one instance, tiny 8x6 rasters for frame-level behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_d;
  logic rst_s;
  logic rst_p;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(10), .FRM_W(16)) if_d ();
  vga_timing_gen_if #(.CNT_W(4),  .FRM_W(8))  if_s ();
  vga_timing_gen_if #(.CNT_W(4),  .FRM_W(2))  if_p ();

  vga_timing_gen u_def (
    .clk   (clk),
    .reset (rst_d),
    .vif   (if_d.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .CNT_W(4), .FRM_W(8)
  ) u_small (
    .clk   (clk),
    .reset (rst_s),
    .vif   (if_s.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(2), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .FRM_W(2)
  ) u_pol (
    .clk   (clk),
    .reset (rst_p),
    .vif   (if_p.master)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int bad, first_pix, first_fs, last_pix, gap_err, hs_cnt, hs_min, hs_max;
    int act_cnt, act_bad, vs_low, ls_n, ls1, ls2;
    int nopix, vs_cnt, vs_bad, hs_bad, fs_n, fs_a, fs_b, guard, n, lx, ly;
    int gaps, pulsed, low_left, hs_hi, vs_hi_bad;

    rst_d = 1'b1; rst_s = 1'b1; rst_p = 1'b1;
    if_d.run = 1'b1; if_s.run = 1'b0; if_p.run = 1'b0;

    // ---------------- reset on default instance ----------------
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_d.pix_en | if_d.line_start | if_d.frame_start | if_d.active_nblank | if_d.running)
        bad++;
    end
    check("rst_strobes", bad, 0);
    check("rst_hs", int'(if_d.hs), 1);
    check("rst_vs", int'(if_d.vs), 1);
    check("rst_x", int'(if_d.draw_x), 0);
    check("rst_y", int'(if_d.draw_y), 0);
    check("rst_fc", int'(if_d.frame_count), 0);

    // ---------------- default horizontal timing ----------------
    rst_d = 1'b0;
    first_pix = 0; first_fs = 0; last_pix = 0; gap_err = 0;
    hs_cnt = 0; hs_min = -1; hs_max = -1; act_cnt = 0; act_bad = 0;
    vs_low = 0; ls_n = 0; ls1 = 0; ls2 = 0;
    for (int cyc = 1; cyc <= 6420; cyc++) begin
      @(negedge clk);
      if (!if_d.vs) vs_low++;
      if (if_d.active_nblank && if_d.draw_x >= 10'd640) act_bad++;
      if (if_d.pix_en) begin
        if (first_pix == 0) begin
          first_pix = cyc;
          first_fs  = int'(if_d.frame_start);
        end
        if (last_pix != 0 && (cyc - last_pix) != 4) gap_err++;
        last_pix = cyc;
        if (if_d.draw_y == 10'd0) begin
          if (!if_d.hs) begin
            hs_cnt++;
            if (hs_min < 0) hs_min = int'(if_d.draw_x);
            hs_max = int'(if_d.draw_x);
          end
          if (if_d.active_nblank) act_cnt++;
        end
        if (if_d.line_start) begin
          ls_n++;
          if (ls_n == 1) ls1 = cyc;
          else if (ls_n == 2) ls2 = cyc;
        end
      end
    end
    check("def_first_pix", first_pix, 4);
    check("def_first_fs", first_fs, 1);
    check("def_pix_gap", gap_err, 0);
    check("def_hs_cnt", hs_cnt, 96);
    check("def_hs_min", hs_min, 656);
    check("def_hs_max", hs_max, 751);
    check("def_act_cnt", act_cnt, 640);
    check("def_act_bad", act_bad, 0);
    check("def_vs_low", vs_low, 0);
    check("def_line_cnt", ls_n, 3);
    check("def_line_period", ls2 - ls1, 3200);
    check("def_y_end", int'(if_d.draw_y), 2);
    rst_d = 1'b1;
    if_d.run = 1'b0;

    // ---------------- small: vertical timing and frame count ----------------
    @(negedge clk);
    rst_s = 1'b0; if_s.run = 1'b1;
    nopix = 0; vs_cnt = 0; vs_bad = 0; hs_cnt = 0; hs_bad = 0; act_cnt = 0;
    fs_n = 0; fs_a = 0; fs_b = 0;
    for (int cyc = 1; cyc <= 96; cyc++) begin
      @(negedge clk);
      if (!if_s.pix_en) nopix++;
      if (!if_s.vs) begin
        vs_cnt++;
        if (if_s.draw_y != 4'd4) vs_bad++;
      end
      if (!if_s.hs) begin
        hs_cnt++;
        if (if_s.draw_x != 4'd5 && if_s.draw_x != 4'd6) hs_bad++;
      end
      if (if_s.active_nblank) act_cnt++;
      if (if_s.frame_start) begin
        fs_n++;
        if (fs_n == 1) fs_a = cyc;
        else if (fs_n == 2) fs_b = cyc;
      end
    end
    check("sm_nopix", nopix, 0);
    check("sm_vs_cnt", vs_cnt, 16);
    check("sm_vs_bad", vs_bad, 0);
    check("sm_hs_cnt", hs_cnt, 24);
    check("sm_hs_bad", hs_bad, 0);
    check("sm_act_cnt", act_cnt, 24);
    check("sm_fs_first", fs_a, 1);
    check("sm_fs_period", fs_b - fs_a, 48);
    @(negedge clk);
    check("sm_fc2", int'(if_s.frame_count), 2);
    check("sm_wrap_xy", int'(if_s.draw_x) + int'(if_s.draw_y), 0);

    // ---------------- small: stop at frame boundary ----------------
    guard = 0;
    while (!(if_s.draw_x == 4'd2 && if_s.draw_y == 4'd1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("stop_found", int'(guard < 100), 1);
    if_s.run = 1'b0;
    n = 0; lx = -1; ly = -1;
    for (int i = 0; i < 60 && if_s.running; i++) begin
      if (if_s.pix_en) begin
        n++;
        lx = int'(if_s.draw_x);
        ly = int'(if_s.draw_y);
      end
      @(negedge clk);
    end
    check("stop_pix_cnt", n, 38);
    check("stop_last_x", lx, 7);
    check("stop_last_y", ly, 5);
    check("stop_running", int'(if_s.running), 0);
    check("stop_fc", int'(if_s.frame_count), 3);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_s.pix_en | if_s.line_start | if_s.frame_start | if_s.running) bad++;
    end
    check("idle_quiet", bad, 0);

    // ---------------- small: re-arm during drain ----------------
    if_s.run = 1'b1;
    gaps = 0; pulsed = 0; low_left = 0; fs_n = 0; fs_a = 0; fs_b = 0;
    for (int cyc = 1; cyc <= 97; cyc++) begin
      @(negedge clk);
      if (!if_s.pix_en || !if_s.running) gaps++;
      if (if_s.frame_start) begin
        fs_n++;
        if (fs_n == 1) fs_a = cyc;
        else if (fs_n == 2) fs_b = cyc;
      end
      if (low_left > 0) begin
        low_left--;
        if (low_left == 0) if_s.run = 1'b1;
      end else if (pulsed == 0 && if_s.draw_x == 4'd3 && if_s.draw_y == 4'd2) begin
        pulsed = 1;
        if_s.run = 1'b0;
        low_left = 3;
      end
    end
    check("rearm_pulsed", pulsed, 1);
    check("rearm_gaps", gaps, 0);
    check("rearm_fs_first", fs_a, 1);
    check("rearm_fs_second", fs_b, 49);
    check("rearm_fs_cnt", fs_n, 3);
    check("rearm_fc", int'(if_s.frame_count), 5);

    // ---------------- small: reset mid-frame ----------------
    guard = 0;
    while (!(if_s.draw_x == 4'd5 && if_s.draw_y == 4'd2) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("mid_found", int'(guard < 100), 1);
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_fc", int'(if_s.frame_count), 0);
    check("mid_rst_xy", int'(if_s.draw_x) + int'(if_s.draw_y), 0);
    check("mid_rst_run", int'(if_s.running), 0);
    check("mid_rst_pix", int'(if_s.pix_en), 0);
    rst_s = 1'b0;
    @(negedge clk);
    check("mid_fs", int'(if_s.frame_start), 1);
    check("mid_running", int'(if_s.running), 1);
    check("mid_fc", int'(if_s.frame_count), 0);
    rst_s = 1'b1;
    if_s.run = 1'b0;

    // ---------------- positive polarity, CLK_DIV=2, frame_count wrap ----------------
    @(negedge clk);
    check("pol_rst_hs", int'(if_p.hs), 0);
    check("pol_rst_vs", int'(if_p.vs), 0);
    rst_p = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_p.pix_en | if_p.running | if_p.hs | if_p.vs) bad++;
    end
    check("pol_idle", bad, 0);
    if_p.run = 1'b1;
    first_pix = 0; first_fs = 0; hs_hi = 0; hs_bad = 0; vs_hi_bad = 0;
    for (int cyc = 1; cyc <= 385; cyc++) begin
      @(negedge clk);
      if (if_p.pix_en) begin
        if (first_pix == 0) begin
          first_pix = cyc;
          first_fs  = int'(if_p.frame_start);
        end
        if (if_p.hs) begin
          hs_hi++;
          if (if_p.draw_x != 4'd5 && if_p.draw_x != 4'd6) hs_bad++;
        end
      end
      if (if_p.vs && if_p.draw_y != 4'd4) vs_hi_bad++;
      if (cyc == 289) check("pol_fc3", int'(if_p.frame_count), 3);
    end
    check("pol_first_pix", first_pix, 2);
    check("pol_first_fs", first_fs, 1);
    check("pol_hs_hi", hs_hi, 48);
    check("pol_hs_bad", hs_bad, 0);
    check("pol_vs_bad", vs_hi_bad, 0);
    check("pol_fc_wrap", int'(if_p.frame_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
